// File: rtl/maquina_pkg.sv
// Shared codes for the vending controller: controller states, key codes and
// the entrada_codigo FSM encoding.
package maquina_pkg;

  localparam logic [1:0] ESPERA     = 2'b00;
  localparam logic [1:0] PRODUTO    = 2'b01;
  localparam logic [1:0] COMPARADOR = 2'b10;

  localparam logic [3:0] CONFIRMA = 4'hA;
  localparam logic [3:0] CANCELA  = 4'hB;

  typedef enum logic [1:0] {
    VAZIO        = 2'b00,
    UM_DIGITO    = 2'b01,
    DOIS_DIGITOS = 2'b10,
    ENVIADO      = 2'b11
  } entrada_estado_t;

  function automatic logic eh_digito(input logic [3:0] k);
    return k <= 4'h9;
  endfunction

endpackage

// File: rtl/contador_timeout.sv
// Inactivity counter for a partial code entry; counts up while enabled and
// flags expiry once the count reaches LIMITE-1.
module contador_timeout #(
  parameter int LIMITE = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  logic [15:0] cnt;

  assign expired = (cnt == 16'(LIMITE - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/entrada_codigo.sv
// Two-digit product code entry from the keypad. Optional inactivity timeout
// for partial entries is built when ENTRADA_CODIGO_TIMEOUT_EN is defined.
//
// state        | meaning
// VAZIO        | no digits held
// UM_DIGITO    | one digit held, waiting for second digit or CONFIRMA
// DOIS_DIGITOS | two digits held, waiting for CONFIRMA
// ENVIADO      | code confirmed, waiting for controller to leave and return to ESPERA
module entrada_codigo
  import maquina_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tecla_valida,
  input  logic [3:0] tecla,
  input  logic [1:0] estado_ctrl,
  output logic [7:0] codigo,
  output logic       codigo_digitado,
  output logic [1:0] digitos,
  output logic       timeout_pulso
);

  entrada_estado_t state, state_next;
  logic [7:0] codigo_next;
  logic [1:0] digitos_next;
  logic       digitado_next;
  logic       saiu_espera, saiu_next;
  logic       key_aceita, eh_dig, eh_conf, eh_canc;
  logic       parcial, tempo_esgotado;

  // Keys 0xC-0xF never count as accepted, so they cannot even restart the timer.
  assign key_aceita = tecla_valida && (tecla <= CANCELA) &&
                      ((estado_ctrl == ESPERA) || (state == ENVIADO));
  assign eh_dig  = key_aceita && eh_digito(tecla);
  assign eh_conf = key_aceita && (tecla == CONFIRMA);
  assign eh_canc = key_aceita && (tecla == CANCELA);
  assign parcial = (state == UM_DIGITO) || (state == DOIS_DIGITOS);

`ifdef ENTRADA_CODIGO_TIMEOUT_EN
  logic timeout_next;

  contador_timeout #(.LIMITE(TIMEOUT_CYCLES)) u_contador (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (parcial),
    .clear   (key_aceita || !parcial),
    .expired (tempo_esgotado)
  );

  assign timeout_next = parcial && tempo_esgotado && !key_aceita;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) timeout_pulso <= 1'b0;
    else        timeout_pulso <= timeout_next;
  end
`else
  assign tempo_esgotado = 1'b0;
  assign timeout_pulso  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= VAZIO;
      codigo          <= 8'h00;
      digitos         <= 2'd0;
      codigo_digitado <= 1'b0;
      saiu_espera     <= 1'b0;
    end else begin
      state           <= state_next;
      codigo          <= codigo_next;
      digitos         <= digitos_next;
      codigo_digitado <= digitado_next;
      saiu_espera     <= saiu_next;
    end
  end

  always_comb begin
    state_next = state;
    if (eh_canc) begin
      state_next = VAZIO;
    end else begin
      case (state)
        VAZIO: begin
          if (eh_dig) state_next = UM_DIGITO;
        end
        UM_DIGITO: begin
          if (eh_dig)                              state_next = DOIS_DIGITOS;
          else if (eh_conf)                        state_next = ENVIADO;
          else if (!key_aceita && tempo_esgotado)  state_next = VAZIO;
        end
        DOIS_DIGITOS: begin
          if (eh_conf)                             state_next = ENVIADO;
          else if (!key_aceita && tempo_esgotado)  state_next = VAZIO;
        end
        ENVIADO: begin
          if (saiu_espera && (estado_ctrl == ESPERA)) state_next = VAZIO;
        end
        default: state_next = VAZIO;
      endcase
    end
  end

  always_comb begin
    codigo_next   = codigo;
    digitos_next  = digitos;
    digitado_next = 1'b0;
    saiu_next     = saiu_espera;
    if (state_next == VAZIO) begin
      codigo_next  = 8'h00;
      digitos_next = 2'd0;
      saiu_next    = 1'b0;
    end else if (state == VAZIO && state_next == UM_DIGITO) begin
      codigo_next  = {4'h0, tecla};
      digitos_next = 2'd1;
    end else if (state == UM_DIGITO && state_next == DOIS_DIGITOS) begin
      codigo_next  = {codigo[3:0], tecla};
      digitos_next = 2'd2;
    end else if (state != ENVIADO && state_next == ENVIADO) begin
      digitado_next = 1'b1;
      saiu_next     = 1'b0;
    end else if (state == ENVIADO && estado_ctrl != ESPERA) begin
      saiu_next = 1'b1;
    end
  end

endmodule

// File: tb/tb_entrada_codigo.sv
// Bench for entrada_codigo: directed scenarios plus random keypad traffic,
// all checked against a digit-list reference model.
module tb_entrada_codigo;

`ifdef ENTRADA_CODIGO_TIMEOUT_EN
  localparam int T     = 8;
  localparam bit TO_EN = 1'b1;
`else
  localparam int T     = 1000;
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tecla_valida;
  logic [3:0] tecla;
  logic [1:0] estado_ctrl;
  logic [7:0] codigo;
  logic       codigo_digitado;
  logic [1:0] digitos;
  logic       timeout_pulso;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: held digits, confirmation status, idle time
  int         m_ndig;
  logic [7:0] m_code;
  bit         m_sent, m_left, m_pulse, m_tpulse;
  int         m_idle;

  entrada_codigo #(.TIMEOUT_CYCLES(T)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .tecla_valida    (tecla_valida),
    .tecla           (tecla),
    .estado_ctrl     (estado_ctrl),
    .codigo          (codigo),
    .codigo_digitado (codigo_digitado),
    .digitos         (digitos),
    .timeout_pulso   (timeout_pulso)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_ndig = 0; m_code = 8'h00; m_sent = 0; m_left = 0; m_idle = 0;
  endtask

  task automatic model_reset();
    model_clear();
    m_pulse = 0; m_tpulse = 0;
  endtask

  task automatic model_step(input bit v, input int k, input int ctrl);
    bit acc;
    m_pulse = 0; m_tpulse = 0;
    acc = v && (ctrl == 0 || m_sent) && k <= 11;
    if (acc && k == 11) begin
      model_clear();
    end else if (m_sent) begin
      if (m_left && ctrl == 0) model_clear();
      else if (ctrl != 0)      m_left = 1;
    end else if (acc && k <= 9) begin
      if (m_ndig < 2) begin
        m_code = {m_code[3:0], 4'(k)};
        m_ndig++;
      end
      m_idle = 0;
    end else if (acc && k == 10) begin
      if (m_ndig > 0) begin
        m_sent = 1; m_left = 0; m_pulse = 1;
      end
      m_idle = 0;
    end else if (TO_EN && m_ndig > 0) begin
      if (m_idle == T - 1) begin
        model_clear();
        m_tpulse = 1;
      end else begin
        m_idle++;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check_eq({tag, ".codigo"},  16'(codigo),          16'(m_code));
    check_eq({tag, ".digitos"}, 16'(digitos),         16'(m_ndig));
    check_eq({tag, ".pulso"},   16'(codigo_digitado), 16'(m_pulse));
    check_eq({tag, ".timeout"}, 16'(timeout_pulso),   16'(m_tpulse));
  endtask

  // one clock: drive at negedge, model at posedge, compare at next negedge
  task automatic cyc(input bit v, input int k, input int ctrl, input string tag);
    tecla_valida = v;
    tecla        = 4'(k);
    estado_ctrl  = 2'(ctrl);
    @(posedge clk);
    model_step(v, k, ctrl);
    @(negedge clk);
    compare_all(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all("rst_async");
    @(posedge clk);
    @(negedge clk);
    compare_all("rst_hold");
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; tecla_valida = 1'b0; tecla = 4'h0; estado_ctrl = 2'b00;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_eq("reset.codigo",  16'(codigo),          16'h00);
    check_eq("reset.digitos", 16'(digitos),         16'h0);
    check_eq("reset.pulso",   16'(codigo_digitado), 16'h0);
    check_eq("reset.timeout", 16'(timeout_pulso),   16'h0);
    rst_n = 1'b1;

    // 4, 2, A -> 0x42 with pulse the cycle after A
    cyc(1, 4, 0, "k42_4");
    check_eq("k42_first", 16'(codigo), 16'h04);
    cyc(1, 2, 0, "k42_2");
    cyc(1, 10, 0, "k42_A");
    check_eq("k42_codigo", 16'(codigo), 16'h42);
    check_eq("k42_digitos", 16'(digitos), 16'd2);
    check_eq("k42_pulse", 16'(codigo_digitado), 16'd1);
    cyc(0, 0, 0, "k42_after");
    check_eq("k42_pulse_end", 16'(codigo_digitado), 16'd0);
    cyc(1, 11, 0, "k42_cancel");

    // 7, A then controller cycles 00 -> 01 -> 00
    cyc(1, 7, 0, "k7");
    cyc(1, 10, 0, "k7_A");
    check_eq("k7_codigo", 16'(codigo), 16'h07);
    cyc(0, 0, 0, "k7_wait");
    cyc(0, 0, 1, "k7_prod");
    cyc(0, 0, 1, "k7_prod2");
    check_eq("k7_held", 16'(codigo), 16'h07);
    cyc(0, 0, 0, "k7_back");
    check_eq("k7_cleared", 16'(codigo), 16'h00);

    // 1, 2, 3, B
    cyc(1, 1, 0, "k123_1");
    cyc(1, 2, 0, "k123_2");
    cyc(1, 3, 0, "k123_3");
    check_eq("k123_no_wrap", 16'(codigo), 16'h12);
    cyc(1, 11, 0, "k123_B");
    check_eq("k123_cancel", 16'(codigo), 16'h00);
    check_eq("k123_no_pulse", 16'(codigo_digitado), 16'd0);

    // gated by controller state; ignored keys in VAZIO
    cyc(1, 5, 2, "gate_5");
    cyc(1, 10, 2, "gate_A");
    check_eq("gate_digitos", 16'(digitos), 16'd0);
    cyc(1, 14, 0, "vazio_E");
    cyc(1, 10, 0, "vazio_A");
    check_eq("vazio_pulse", 16'(codigo_digitado), 16'd0);

    if (TO_EN) begin
      cyc(1, 9, 0, "to_9");
      for (int i = 0; i < T - 1; i++) cyc(0, 0, 0, "to_idle");
      check_eq("to_before", 16'(timeout_pulso), 16'd0);
      cyc(0, 0, 0, "to_expire");
      check_eq("to_pulse", 16'(timeout_pulso), 16'd1);
      check_eq("to_codigo", 16'(codigo), 16'h00);
      cyc(1, 9, 0, "tk_9");
      for (int i = 0; i < T - 1; i++) cyc(0, 0, 0, "tk_idle");
      cyc(1, 3, 0, "tk_key_wins");
      check_eq("tk_codigo", 16'(codigo), 16'h93);
      check_eq("tk_no_pulse", 16'(timeout_pulso), 16'd0);
      for (int i = 0; i < T; i++) cyc(0, 0, 0, "tk_idle2");
      check_eq("tk_late_pulse", 16'(timeout_pulso), 16'd1);
    end

    // reset during the pulse cycle aborts everything
    cyc(1, 6, 0, "rp_6");
    cyc(1, 10, 0, "rp_A");
    check_eq("rp_pulse_on", 16'(codigo_digitado), 16'd1);
    do_reset();
    check_eq("rp_pulse_off", 16'(codigo_digitado), 16'd0);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      int r, c;
      r = int'($urandom_range(0, 9));
      c = (r < 7) ? 0 : (r < 9) ? 1 : 2;
      if ($urandom_range(0, 299) == 0) do_reset();
      else cyc(bit'($urandom_range(0, 1)), int'($urandom_range(0, 15)), c, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/entrada_codigo.md
ENTRADA_CODIGO -- requirements
Module: entrada_codigo

Interface
- REQ-001: Parameter TIMEOUT_CYCLES, default 1000, inactivity limit in clk cycles for a partial entry (used only when ENTRADA_CODIGO_TIMEOUT_EN is defined); legal range 2..65535.
- REQ-002: clk  input  1  single clock, all state updates on its rising edge.
- REQ-003: rst_n  input  1  reset, asynchronous and active-low.
- REQ-004: tecla_valida  input  1  one-cycle strobe; tecla is valid in that cycle.
- REQ-005: tecla  input  4  key code: 0x0-0x9 digit; 0xA CONFIRMA; 0xB CANCELA; 0xC-0xF ignored.
- REQ-006: estado_ctrl  input  2  main controller state (00 ESPERA, 01 PRODUTO, 10 COMPARADOR).
- REQ-007: codigo  output  8  two BCD digits of the product code, tens in [7:4], units in [3:0].
- REQ-008: codigo_digitado  output  1  one-cycle pulse; code complete and confirmed.
- REQ-009: digitos  output  2  number of digits currently held (0, 1, 2).
- REQ-010: timeout_pulso  output  1  one-cycle pulse when a partial entry is discarded by timeout.

Function
- REQ-011: FSM states SHALL be VAZIO, UM_DIGITO, DOIS_DIGITOS and ENVIADO, all registered.
- REQ-012: A key SHALL be accepted only when tecla_valida=1 and (estado_ctrl=00 or state=ENVIADO); otherwise it is ignored with no state change.
- REQ-013: A digit in VAZIO SHALL set codigo={4'h0,d}, digitos=1, state UM_DIGITO, visible the cycle after the strobe.
- REQ-014: A digit in UM_DIGITO SHALL set codigo={codigo[3:0],d}, digitos=2, state DOIS_DIGITOS.
- REQ-015: A digit in DOIS_DIGITOS or ENVIADO SHALL be ignored (no overwrite, no wrap).
- REQ-016: CONFIRMA in UM_DIGITO or DOIS_DIGITOS SHALL move to ENVIADO and drive codigo_digitado=1 for exactly the next cycle; codigo is held unchanged.
- REQ-017: CONFIRMA in VAZIO or ENVIADO SHALL be ignored.
- REQ-018: CANCELA in any state SHALL move to VAZIO with codigo=00 and digitos=0 the next cycle; no pulse is emitted.
- REQ-019: In ENVIADO the block SHALL wait for estado_ctrl to leave 00, then on estado_ctrl returning to 00 move to VAZIO, clearing codigo and digitos.
- REQ-020: Keys 0xC-0xF SHALL have no effect in any state.
- REQ-021: Outputs SHALL be registered; no combinational path from any input to any output.

Reset
- REQ-022: While rst_n=0: state VAZIO, codigo=00, digitos=0, codigo_digitado=0, timeout_pulso=0, timeout counter=0, the "left ESPERA" flag cleared.
- REQ-023: Reset asserted mid-entry or during the codigo_digitado pulse SHALL abort immediately; no pulse completes after reset.

Configuration
- REQ-024: With ENTRADA_CODIGO_TIMEOUT_EN defined, a counter SHALL run in UM_DIGITO and DOIS_DIGITOS, clear on every accepted key, and on reaching TIMEOUT_CYCLES-1 force VAZIO, clear codigo and digitos, and pulse timeout_pulso for one cycle.
- REQ-025: On a key accepted in the expiry cycle, the key SHALL win and the counter SHALL restart.
- REQ-026: Without ENTRADA_CODIGO_TIMEOUT_EN, no counter logic SHALL exist, timeout_pulso SHALL be tied 0, and partial entries persist indefinitely.

Structure
- REQ-027: Shared package maquina_pkg SHALL hold controller state codes (ESPERA, PRODUTO, COMPARADOR), key codes (CONFIRMA, CANCELA) and the entrada_codigo state encoding.
- REQ-028: The timeout counter SHALL be one sub-module, contador_timeout (enable, clear, expired), instantiated only under the macro.

Verification
- REQ-029: Keys 4, 2, A with estado_ctrl=00 -> codigo=0x42, digitos=2, codigo_digitado high exactly one cycle after the A strobe.
- REQ-030: Keys 7, A -> codigo=0x07 and pulse; then estado_ctrl 00->01->00 -> state VAZIO, codigo=0x00.
- REQ-031: Keys 1, 2, 3, B -> codigo stays 0x12 after the 3; the B gives codigo=0x00, digitos=0, no pulse.
- REQ-032: estado_ctrl=10 with keys 5, A -> no change, no pulse; key E or A in VAZIO -> no change.
- REQ-033: Macro defined, TIMEOUT_CYCLES=8, key 9 then idle -> timeout_pulso one cycle, codigo=0x00; a key on the expiry cycle restarts the count instead.
- REQ-034: rst_n low in the cycle after A -> codigo_digitado=0 and all outputs at reset values, asynchronously.
